// File: rtl/mine_field_dp_if.sv
// Command/response bundle between the game controller, the minesweeper datapath and the display.
interface mine_field_dp_if #(
    parameter int unsigned ROWS    = 5,
    parameter int unsigned COLS    = 5,
    parameter int unsigned SCORE_W = 32
);
    localparam int unsigned N     = ROWS * COLS;
    localparam int unsigned IDX_W = $clog2(N);

    logic               start;
    logic [N-1:0]       mines_in;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [IDX_W-1:0]   data;
    logic               resp_valid;
    logic               resp_ready;
    logic [3:0]         n_nearby;
    logic               err;
    logic               gameover;
    logic               win;
    logic [N-1:0]       cleared;
    logic [SCORE_W-1:0] global_score;

    modport master (
        output start, mines_in, cmd_valid, data, resp_ready,
        input  cmd_ready, resp_valid, n_nearby, err, gameover, win, cleared, global_score
    );

    modport slave (
        input  start, mines_in, cmd_valid, data, resp_ready,
        output cmd_ready, resp_valid, n_nearby, err, gameover, win, cleared, global_score
    );
endinterface

// File: rtl/mine_field_dp.sv
// Minesweeper datapath: validates a selected cell, counts its mines one neighbour per cycle.
// Optional MINE_AUTO_CLEAR_EN: a zero-count cell also clears its in-bound neighbours.
module mine_field_dp #(
    parameter int unsigned ROWS    = 5,
    parameter int unsigned COLS    = 5,
    parameter int unsigned SCORE_W = 32
) (
    input  logic           clka,
    input  logic           restart_n,
    mine_field_dp_if.slave bus
);
    localparam int unsigned N     = ROWS * COLS;
    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned RC_W  = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned K_W   = 3;

    typedef enum logic [2:0] {
        S_IDLE, S_READY, S_CHECK, S_SCAN, S_RESOLVE, S_DONE
    } state_e;

    state_e             state_q,      state_d;
    logic [N-1:0]       mines_q,      mines_d;
    logic [N-1:0]       cleared_q,    cleared_d;
    logic [IDX_W-1:0]   data_q,       data_d;
    logic [RC_W-1:0]    row_q,        row_d;
    logic [RC_W-1:0]    col_q,        col_d;
    logic [K_W-1:0]     k_q,          k_d;
    logic [CNT_W-1:0]   counter_q,    counter_d;
    logic [3:0]         n_nearby_q,   n_nearby_d;
    logic               err_q,        err_d;
    logic               gameover_q,   gameover_d;
    logic               win_q,        win_d;
    logic [SCORE_W-1:0] score_q,      score_d;
    logic               cmd_ready_q,  cmd_ready_d;
    logic               resp_valid_q, resp_valid_d;
    logic               oob;

    // Neighbour k offsets, row-major around the centre cell.
    function automatic int nbr_dr(input logic [K_W-1:0] k);
        case (k)
            3'd0, 3'd1, 3'd2: return -1;
            3'd3, 3'd4:       return 0;
            default:          return 1;
        endcase
    endfunction

    function automatic int nbr_dc(input logic [K_W-1:0] k);
        case (k)
            3'd0, 3'd3, 3'd5: return -1;
            3'd1, 3'd6:       return 0;
            default:          return 1;
        endcase
    endfunction

    function automatic logic nbr_in(input logic [RC_W-1:0] r, input logic [RC_W-1:0] c,
                                    input logic [K_W-1:0] k);
        int nr;
        int nc;
        nr = int'(r) + nbr_dr(k);
        nc = int'(c) + nbr_dc(k);
        return (nr >= 0) && (nr < int'(ROWS)) && (nc >= 0) && (nc < int'(COLS));
    endfunction

    // Only meaningful when nbr_in() holds for the same arguments.
    function automatic logic [IDX_W-1:0] nbr_idx(input logic [RC_W-1:0] r, input logic [RC_W-1:0] c,
                                                 input logic [K_W-1:0] k);
        return IDX_W'((int'(r) + nbr_dr(k)) * int'(COLS) + int'(c) + nbr_dc(k));
    endfunction

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            state_q      <= S_IDLE;
            mines_q      <= '0;
            cleared_q    <= '0;
            data_q       <= '0;
            row_q        <= '0;
            col_q        <= '0;
            k_q          <= '0;
            counter_q    <= '0;
            n_nearby_q   <= '0;
            err_q        <= 1'b0;
            gameover_q   <= 1'b0;
            win_q        <= 1'b0;
            score_q      <= '0;
            cmd_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mines_q      <= mines_d;
            cleared_q    <= cleared_d;
            data_q       <= data_d;
            row_q        <= row_d;
            col_q        <= col_d;
            k_q          <= k_d;
            counter_q    <= counter_d;
            n_nearby_q   <= n_nearby_d;
            err_q        <= err_d;
            gameover_q   <= gameover_d;
            win_q        <= win_d;
            score_q      <= score_d;
            cmd_ready_q  <= cmd_ready_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mines_d    = mines_q;
        cleared_d  = cleared_q;
        data_d     = data_q;
        row_d      = row_q;
        col_d      = col_q;
        k_d        = k_q;
        counter_d  = counter_q;
        n_nearby_d = n_nearby_q;
        err_d      = err_q;
        gameover_d = gameover_q;
        win_d      = win_q;
        score_d    = score_q;
        oob        = int'(data_q) >= int'(N);

        case (state_q)
            S_IDLE: ;
            S_READY: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    data_d  = bus.data;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (oob) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (cleared_q[data_q]) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (mines_q[data_q]) begin
                    err_d              = 1'b0;
                    gameover_d         = 1'b1;
                    cleared_d[data_q]  = 1'b1;
                    state_d            = S_DONE;
                end else begin
                    err_d     = 1'b0;
                    counter_d = '0;
                    k_d       = '0;
                    row_d     = RC_W'(int'(data_q) / int'(COLS));
                    col_d     = RC_W'(int'(data_q) % int'(COLS));
                    state_d   = S_SCAN;
                end
            end
            S_SCAN: begin
                if (nbr_in(row_q, col_q, k_q) && mines_q[nbr_idx(row_q, col_q, k_q)]) begin
                    counter_d = counter_q + CNT_W'(1);
                end
                if (k_q == K_W'(7)) begin
                    state_d = S_RESOLVE;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            S_RESOLVE: begin
                cleared_d[data_q] = 1'b1;
                n_nearby_d        = counter_q;
`ifdef MINE_AUTO_CLEAR_EN
                if (counter_q == '0) begin
                    for (int k = 0; k < 8; k++) begin
                        if (nbr_in(row_q, col_q, K_W'(k))) begin
                            cleared_d[nbr_idx(row_q, col_q, K_W'(k))] = 1'b1;
                        end
                    end
                end
`endif
                if (&(mines_q | cleared_d)) begin
                    win_d      = 1'b1;
                    gameover_d = 1'b1;
                    if (score_q != '1) begin
                        score_d = score_q + SCORE_W'(1);
                    end
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.resp_ready) begin
                    state_d = S_READY;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // New game overrides everything in flight, but the win tally survives.
        if (bus.start) begin
            mines_d    = bus.mines_in;
            cleared_d  = '0;
            gameover_d = 1'b0;
            win_d      = 1'b0;
            n_nearby_d = '0;
            err_d      = 1'b0;
            state_d    = S_READY;
        end

        cmd_ready_d  = (state_d == S_READY) && !gameover_d;
        resp_valid_d = (state_d == S_DONE);
    end

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.n_nearby     = n_nearby_q;
    assign bus.err          = err_q;
    assign bus.gameover     = gameover_q;
    assign bus.win          = win_q;
    assign bus.cleared      = cleared_q;
    assign bus.global_score = score_q;
endmodule

// File: tb/tb_mine_field_dp.sv
// Directed bench for mine_field_dp: a 5x5 board and a 2x2 board share clock and reset.
module tb_mine_field_dp;
    logic clka = 1'b0;
    logic restart_n;
    int   checks = 0;
    int   errors = 0;
    int   lat;

    always #5 clka = ~clka;

    mine_field_dp_if #(.ROWS(5), .COLS(5), .SCORE_W(32)) b5 ();
    mine_field_dp_if #(.ROWS(2), .COLS(2), .SCORE_W(32)) b2 ();

    mine_field_dp #(.ROWS(5), .COLS(5), .SCORE_W(32)) dut5 (
        .clka(clka), .restart_n(restart_n), .bus(b5));
    mine_field_dp #(.ROWS(2), .COLS(2), .SCORE_W(32)) dut2 (
        .clka(clka), .restart_n(restart_n), .bus(b2));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic start5(input logic [24:0] m);
        b5.mines_in = m;
        b5.start    = 1'b1;
        tick();
        b5.start    = 1'b0;
    endtask

    task automatic start2(input logic [3:0] m);
        b2.mines_in = m;
        b2.start    = 1'b1;
        tick();
        b2.start    = 1'b0;
    endtask

    // Issue one command and return cycles from the accepting edge to resp_valid.
    task automatic cmd5(input int idx, output int l);
        int w;
        w = 0;
        while (!b5.cmd_ready && w < 20) begin
            tick();
            w++;
        end
        check("cmd5_ready", 64'(b5.cmd_ready), 64'd1);
        b5.data      = 5'(idx);
        b5.cmd_valid = 1'b1;
        tick();
        b5.cmd_valid = 1'b0;
        l = 0;
        while (!b5.resp_valid && l < 40) begin
            tick();
            l++;
        end
    endtask

    task automatic cmd2(input int idx, output int l);
        int w;
        w = 0;
        while (!b2.cmd_ready && w < 20) begin
            tick();
            w++;
        end
        check("cmd2_ready", 64'(b2.cmd_ready), 64'd1);
        b2.data      = 2'(idx);
        b2.cmd_valid = 1'b1;
        tick();
        b2.cmd_valid = 1'b0;
        l = 0;
        while (!b2.resp_valid && l < 40) begin
            tick();
            l++;
        end
    endtask

    task automatic take5();
        b5.resp_ready = 1'b1;
        tick();
        b5.resp_ready = 1'b0;
    endtask

    task automatic take2();
        b2.resp_ready = 1'b1;
        tick();
        b2.resp_ready = 1'b0;
    endtask

    initial begin
        b5.start = 0; b5.mines_in = '0; b5.cmd_valid = 0; b5.data = '0; b5.resp_ready = 0;
        b2.start = 0; b2.mines_in = '0; b2.cmd_valid = 0; b2.data = '0; b2.resp_ready = 0;
        restart_n = 1'b0;
        repeat (3) tick();
        check("rst_ready",   64'(b5.cmd_ready),    64'd0);
        check("rst_valid",   64'(b5.resp_valid),   64'd0);
        check("rst_cleared", 64'(b5.cleared),      64'd0);
        check("rst_score",   64'(b5.global_score), 64'd0);
        check("rst_gover",   64'(b5.gameover),     64'd0);
        restart_n = 1'b1;
        tick();

        // 2x2 board, mine in cell 0: clearing 1,2,3 wins.
        start2(4'b0001);
        cmd2(1, lat);
        check("b2_c1_lat", 64'(lat), 64'd10);
        check("b2_c1_n",   64'(b2.n_nearby), 64'd1);
        take2();
        cmd2(2, lat);
        check("b2_c2_n",   64'(b2.n_nearby), 64'd1);
        check("b2_c2_win", 64'(b2.win), 64'd0);
        take2();
        cmd2(3, lat);
        check("b2_c3_n",     64'(b2.n_nearby), 64'd1);
        check("b2_win",      64'(b2.win), 64'd1);
        check("b2_gover",    64'(b2.gameover), 64'd1);
        check("b2_score1",   64'(b2.global_score), 64'd1);
        check("b2_cleared",  64'(b2.cleared), 64'hE);
        take2();
        check("b2_post_rdy", 64'(b2.cmd_ready), 64'd0);
        start2(4'b0001);
        for (int c = 1; c < 4; c++) begin
            cmd2(c, lat);
            take2();
        end
        check("b2_score2", 64'(b2.global_score), 64'd2);
        check("b2_win2",   64'(b2.win), 64'd1);
        restart_n = 1'b0;
        #1;
        check("b2_rst_score", 64'(b2.global_score), 64'd0);
        check("b2_rst_win",   64'(b2.win), 64'd0);
        restart_n = 1'b1;
        tick();

        // 5x5 board, mines at cells 1,3,5,15.
        start5(25'h000_802A);
        check("b5_ready", 64'(b5.cmd_ready), 64'd1);
        cmd5(0, lat);
        check("c0_lat",     64'(lat), 64'd10);
        check("c0_n",       64'(b5.n_nearby), 64'd2);
        check("c0_cleared", 64'(b5.cleared), 64'h1);
        check("c0_err",     64'(b5.err), 64'd0);
        take5();
        cmd5(9, lat);
        check("c9_n",       64'(b5.n_nearby), 64'd1);
        check("c9_cleared", 64'(b5.cleared), 64'h201);
        take5();
        cmd5(4, lat);
        check("c4_n",       64'(b5.n_nearby), 64'd1);
        check("c4_cleared", 64'(b5.cleared), 64'h211);
        take5();
        cmd5(25, lat);
        check("c25_lat",     64'(lat), 64'd1);
        check("c25_err",     64'(b5.err), 64'd1);
        check("c25_cleared", 64'(b5.cleared), 64'h211);
        take5();
        cmd5(0, lat);
        check("rep0_lat", 64'(lat), 64'd1);
        check("rep0_err", 64'(b5.err), 64'd1);
        take5();
        cmd5(3, lat);
        check("mine_lat",     64'(lat), 64'd1);
        check("mine_gover",   64'(b5.gameover), 64'd1);
        check("mine_win",     64'(b5.win), 64'd0);
        check("mine_cleared", 64'(b5.cleared), 64'h219);
        take5();
        check("mine_ready", 64'(b5.cmd_ready), 64'd0);

        // Commands after a loss must be ignored.
        b5.data      = 5'd7;
        b5.cmd_valid = 1'b1;
        repeat (12) tick();
        b5.cmd_valid = 1'b0;
        check("ign_valid",   64'(b5.resp_valid), 64'd0);
        check("ign_cleared", 64'(b5.cleared), 64'h219);

        start5(25'h000_802A);
        check("rs_cleared", 64'(b5.cleared), 64'd0);
        check("rs_gover",   64'(b5.gameover), 64'd0);
        check("rs_ready",   64'(b5.cmd_ready), 64'd1);
        cmd5(9, lat);
        check("rs_c9_n", 64'(b5.n_nearby), 64'd1);
        take5();

        // Asynchronous reset while scanning neighbours of cell 0.
        b5.data      = 5'd0;
        b5.cmd_valid = 1'b1;
        tick();
        b5.cmd_valid = 1'b0;
        repeat (4) tick();
        restart_n = 1'b0;
        #1;
        check("scanrst_cleared", 64'(b5.cleared), 64'd0);
        check("scanrst_n",       64'(b5.n_nearby), 64'd0);
        check("scanrst_ready",   64'(b5.cmd_ready), 64'd0);
        check("scanrst_valid",   64'(b5.resp_valid), 64'd0);
        restart_n = 1'b1;
        tick();
        check("idle_ready", 64'(b5.cmd_ready), 64'd0);

        // start while a response is pending discards it.
        start5(25'h000_802A);
        cmd5(0, lat);
        check("pend_valid", 64'(b5.resp_valid), 64'd1);
        b5.start = 1'b1;
        tick();
        b5.start = 1'b0;
        check("disc_valid",   64'(b5.resp_valid), 64'd0);
        check("disc_cleared", 64'(b5.cleared), 64'd0);
        check("disc_n",       64'(b5.n_nearby), 64'd0);
        check("disc_ready",   64'(b5.cmd_ready), 64'd1);
        check("b5_score",     64'(b5.global_score), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
